// File: rtl/lc3_microsequencer.sv
// LC-3 microsequencer: holds the microstate, drives the control-store read port
// and computes the next microstate from IRD/COND/J, plus BEN, instr count, mem watchdog.
//
// Ports:
//   i_CLK, i_RST      clock (rising edge), synchronous active-high reset
//   i_run             advance enable; 0 freezes all state
//   i_micro_word      microinstruction for o_read_addr (combinational store)
//   i_IR              instruction register
//   i_N/i_Z/i_P       condition codes
//   i_R               memory ready
//   i_INT             interrupt pending
//   i_PSR15           privilege bit (1 = user)
//   o_read_en         control-store read enable
//   o_read_addr       current microstate
//   o_BEN             branch-enable register
//   o_instr_count     fetch-state entries, modulo 2^16
//   o_mem_timeout     sticky memory-wait watchdog flag
module lc3_microsequencer #(
  parameter int AddrBusSize = 6,
  parameter int ElementSize = 52,
  parameter int FETCH_STATE = 18,
  parameter int IRD_BIT     = 51,
  parameter int COND_MSB    = 50,
  parameter int J_MSB       = 47,
  parameter int LD_BEN_BIT  = 41,
  parameter int MEM_TIMEOUT = 256
) (
  input  logic                   i_CLK,
  input  logic                   i_RST,
  input  logic                   i_run,
  input  logic [ElementSize-1:0] i_micro_word,
  input  logic [15:0]            i_IR,
  input  logic                   i_N,
  input  logic                   i_Z,
  input  logic                   i_P,
  input  logic                   i_R,
  input  logic                   i_INT,
  input  logic                   i_PSR15,
  output logic                   o_read_en,
  output logic [AddrBusSize-1:0] o_read_addr,
  output logic                   o_BEN,
  output logic [15:0]            o_instr_count,
  output logic                   o_mem_timeout
);

  localparam int WdW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [AddrBusSize-1:0] Fetch = AddrBusSize'(FETCH_STATE);
  localparam logic [WdW-1:0] WdMax = WdW'(MEM_TIMEOUT);

  logic [AddrBusSize-1:0] state_q, state_d;
  logic                   read_en_q;
  logic                   ben_q, ben_d;
  logic [15:0]            count_q, count_d;
  logic [WdW-1:0]         wd_q, wd_d;
  logic                   tout_q, tout_d;

  logic                   ird;
  logic                   ld_ben;
  logic [2:0]             cond;
  logic [AddrBusSize-1:0] j;
  logic                   advance;
  logic                   mem_wait;

  // Fields not decoded here still go through this reduction so lint sees them used.
  logic unused_bits;
  assign unused_bits = ^{i_micro_word, i_IR};

  assign ird     = i_micro_word[IRD_BIT];
  assign ld_ben  = i_micro_word[LD_BEN_BIT];
  assign cond    = i_micro_word[COND_MSB -: 3];
  assign j       = i_micro_word[J_MSB -: AddrBusSize];
  assign advance = i_run & read_en_q;
  assign mem_wait = ~ird & (cond == 3'b001) & ~i_R;

  always_comb begin
    state_d = j;
    if (ird) begin
      state_d = '0;
      state_d[3:0] = i_IR[15:12];
    end else begin
      case (cond)
        3'b001:  state_d[1] = j[1] | i_R;
        3'b010:  state_d[2] = j[2] | ben_q;
        3'b011:  state_d[0] = j[0] | i_IR[11];
        3'b100:  state_d[3] = j[3] | i_INT;
        3'b101:  state_d[4] = j[4] | i_PSR15;
        default: state_d = j;
      endcase
    end
  end

  always_comb begin
    ben_d = ben_q;
    if (ld_ben)
      ben_d = (i_IR[11] & i_N) | (i_IR[10] & i_Z) | (i_IR[9] & i_P);
  end

  always_comb begin
    count_d = count_q;
    if (state_d == Fetch)
      count_d = count_q + 16'd1;
  end

  always_comb begin
    wd_d   = '0;
    tout_d = tout_q;
    if (mem_wait) begin
      wd_d = (wd_q == WdMax) ? WdMax : wd_q + 1'b1;
      if (wd_d == WdMax)
        tout_d = 1'b1;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q   <= Fetch;
      read_en_q <= 1'b0;
      ben_q     <= 1'b0;
      count_q   <= '0;
      wd_q      <= '0;
      tout_q    <= 1'b0;
    end else begin
      read_en_q <= 1'b1;
      if (advance) begin
        state_q <= state_d;
        ben_q   <= ben_d;
        count_q <= count_d;
        wd_q    <= wd_d;
        tout_q  <= tout_d;
      end
    end
  end

  assign o_read_en     = read_en_q;
  assign o_read_addr   = state_q;
  assign o_BEN         = ben_q;
  assign o_instr_count = count_q;
  assign o_mem_timeout = tout_q;

endmodule

// File: tb/tb_lc3_microsequencer.sv
// Directed bench for lc3_microsequencer.
// Bench drives the micro word directly, standing in for the control store.
module tb_lc3_microsequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [51:0] mword;
  logic [15:0] ir;
  logic        n, z, p, r, intr, psr15;
  logic        ren;
  logic [5:0]  addr;
  logic        ben;
  logic [15:0] icnt;
  logic        tout;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lc3_microsequencer dut (
    .i_CLK         (clk),
    .i_RST         (rst),
    .i_run         (run),
    .i_micro_word  (mword),
    .i_IR          (ir),
    .i_N           (n),
    .i_Z           (z),
    .i_P           (p),
    .i_R           (r),
    .i_INT         (intr),
    .i_PSR15       (psr15),
    .o_read_en     (ren),
    .o_read_addr   (addr),
    .o_BEN         (ben),
    .o_instr_count (icnt),
    .o_mem_timeout (tout)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [51:0] mw(input logic       ird,
                                     input logic [2:0] cnd,
                                     input logic [5:0] jj,
                                     input logic       ldb);
    logic [51:0] w;
    w = '0;
    w[51] = ird;
    w[50:48] = cnd;
    w[47:42] = jj;
    w[41] = ldb;
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; run = 1'b1; mword = '0; ir = '0;
    n = 0; z = 0; p = 0; r = 0; intr = 0; psr15 = 0;

    // 1: reset and release
    repeat (3) tick();
    chk("rst_addr", addr, 18);
    chk("rst_en", ren, 0);
    chk("rst_ben", ben, 0);
    chk("rst_cnt", icnt, 0);
    chk("rst_tout", tout, 0);
    rst = 1'b0;
    tick();
    chk("rel_en", ren, 1);
    chk("rel_addr", addr, 18);

    // 2: IRD dispatch
    mword = mw(1, 3'd0, 6'd0, 0); ir = 16'h1234;
    tick();
    chk("ird_1234", addr, 1);
    ir = 16'hF025;
    tick();
    chk("ird_f025", addr, 15);
    chk("ird_cnt", icnt, 0);

    // 3: memory wait then ready
    mword = mw(0, 3'd1, 6'd33, 0); r = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mwait", addr, 33);
    end
    r = 1;
    tick();
    chk("mready", addr, 35);

    // 4: BEN load and branch
    mword = mw(0, 3'd0, 6'd20, 1); ir = 16'h0800; n = 1;
    tick();
    chk("ben_set", ben, 1);
    chk("ben_addr", addr, 20);
    mword = mw(0, 3'd2, 6'd18, 0);
    tick();
    chk("br_taken", addr, 22);
    chk("br_cnt0", icnt, 0);
    mword = mw(0, 3'd0, 6'd10, 1); n = 0; z = 1;
    tick();
    chk("ben_clr", ben, 0);
    mword = mw(0, 3'd2, 6'd18, 0);
    tick();
    chk("br_ntk", addr, 18);
    chk("br_cnt1", icnt, 1);
    // load and branch in one word: branch sees old BEN (0)
    mword = mw(0, 3'd2, 6'd18, 1); n = 1;
    tick();
    chk("simul_addr", addr, 18);
    chk("simul_ben", ben, 1);
    chk("simul_cnt", icnt, 2);

    // 5: freeze then resume
    mword = mw(0, 3'd3, 6'd0, 1); ir = 16'h0000; n = 0; z = 0;
    run = 0;
    repeat (5) tick();
    chk("frz_addr", addr, 18);
    chk("frz_ben", ben, 1);
    chk("frz_cnt", icnt, 2);
    run = 1; ir = 16'h0800;
    tick();
    chk("res_addr", addr, 1);
    chk("res_ben", ben, 0);
    mword = mw(0, 3'd4, 6'd0, 0); intr = 1;
    tick();
    chk("c_int", addr, 8);
    mword = mw(0, 3'd5, 6'd0, 0); psr15 = 1;
    tick();
    chk("c_psr", addr, 16);
    mword = mw(0, 3'd6, 6'd5, 0); r = 1;
    tick();
    chk("c_110", addr, 5);

    // 6: watchdog
    mword = mw(0, 3'd1, 6'd40, 0); r = 0;
    repeat (255) tick();
    chk("wd_255", tout, 0);
    chk("wd_addr", addr, 40);
    tick();
    chk("wd_256", tout, 1);
    tick();
    chk("wd_sat", tout, 1);
    r = 1;
    tick();
    chk("wd_rdy", addr, 42);
    chk("wd_stky", tout, 1);
    rst = 1;
    tick();
    chk("wd_rst", tout, 0);
    chk("wd_raddr", addr, 18);
    chk("wd_rcnt", icnt, 0);

    // instruction counter wrap
    rst = 0;
    tick();
    mword = mw(0, 3'd0, 6'd18, 0);
    repeat (65535) tick();
    chk("cnt_ffff", icnt, 16'hFFFF);
    tick();
    chk("cnt_wrap", icnt, 0);
    chk("cnt_addr", addr, 18);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
